modn_cnt_div: RTL

MODN_CNT_DIV -- requirements
Module: modn_cnt_div

---
 rtl/modn_cnt_div.sv | 92 +++++++++
 1 files changed

// File: rtl/modn_cnt_div.sv
// rtl/modn_cnt_div.sv - Modulo-MOD up/down counter with wrap pulse plus a 50% duty clock divider.
// All state is registered on in_clk and cleared asynchronously by active-low rst.
module modn_cnt_div #(
  parameter int MOD      = 6,
  parameter int W        = 4,
  parameter int DIV_HALF = 3
) (
  input  logic         in_clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] q,
  output logic         carry,
  output logic         out_clk
);

  localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [W-1:0]  CNT_MAX = W'(MOD - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV_HALF - 1);

  if (MOD < 2 || (2 ** W) < MOD || DIV_HALF < 1) begin : g_bad_params
    $error("modn_cnt_div: illegal parameters MOD=%0d W=%0d DIV_HALF=%0d", MOD, W, DIV_HALF);
  end

  logic [W-1:0]  cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          oclk_q, oclk_d;

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      // Out-of-range load values saturate so q can never leave 0..MOD-1.
      cnt_d = (load_val > CNT_MAX) ? CNT_MAX : load_val;
    end else if (en) begin
      if (up) begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          carry_d = 1'b1;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_MAX;
          carry_d = 1'b1;
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
    end
  end

  always_comb begin
    dcnt_d = dcnt_q;
    oclk_d = oclk_q;
    if (clr) begin
      dcnt_d = '0;
      oclk_d = 1'b0;
    end else if (dcnt_q == DIV_MAX) begin
      dcnt_d = '0;
      oclk_d = ~oclk_q;
    end else begin
      dcnt_d = dcnt_q + DW'(1);
    end
  end

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      dcnt_q  <= '0;
      oclk_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      dcnt_q  <= dcnt_d;
      oclk_q  <= oclk_d;
    end
  end

  assign q       = cnt_q;
  assign carry   = carry_q;
  assign out_clk = oclk_q;

endmodule
